// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS_REG register-file reader path.
//   ADDR_W / DATA_W : register address and data widths
//   dump_state_t    : reg_dump_reader FSM states
//   beat_sel_t      : which captured word the output mux presents
//   beat_t          : one output beat {addr, data, last}
// Optional build macro: REG_DUMP_CHECKSUM_EN adds the SUM state / selector.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EMIT_A,
    ST_EMIT_B,
    ST_DONE
`ifdef REG_DUMP_CHECKSUM_EN
    , ST_SUM
`endif
  } dump_state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_A,
    SEL_B
`ifdef REG_DUMP_CHECKSUM_EN
    , SEL_SUM
`endif
  } beat_sel_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/dump_beat_reg.sv
// -----------------------------------------------------------------------------
// dump_beat_reg
// Two-entry capture buffer for one register pair plus the output beat mux.
// The buffers only change on capture, which the FSM issues solely in READ, so
// a presented beat stays stable for as long as the consumer stalls.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   capture          : load data_a/data_b into the pair buffers
//   sel              : which word to present (none / A / B / checksum)
//   pair             : current pair index; beat address is {pair, sel==B}
//   last             : last flag to attach to the presented beat
//   data_a, data_b   : register file read data (combinational ports)
//   clear_sum        : (REG_DUMP_CHECKSUM_EN only) clear the XOR accumulator
//   beat             : presented {addr, data, last}; all zero when sel==NONE
// Optional build macro: REG_DUMP_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module dump_beat_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  beat_sel_t         sel,
  input  logic [ADDR_W-2:0] pair,
  input  logic              last,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
`ifdef REG_DUMP_CHECKSUM_EN
  input  logic              clear_sum,
`endif
  output beat_t             beat
);

  logic [DATA_W-1:0] buf_a;
  logic [DATA_W-1:0] buf_b;

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  // NOTE: these two words are reset even though they are storage: only two
  // entries, and it keeps the idle output deterministic from power-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_a <= '0;
      buf_b <= '0;
    end else if (capture) begin
      buf_a <= data_a;
      buf_b <= data_b;
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Folds the same snapshot that lands in the buffers, so the checksum
  // always agrees with the data actually emitted.
  always_ff @(posedge clk) begin
    if (reset || clear_sum) begin
      sum_q <= '0;
    end else if (capture) begin
      sum_q <= sum_q ^ data_a ^ data_b;
    end
  end
`endif

  // NOTE: every output gets a default first, so no path through the case
  // can leave a bit unassigned and infer a latch.
  always_comb begin
    beat = '0;
    unique case (sel)
      SEL_A: begin
        beat.addr = {pair, 1'b0};
        beat.data = buf_a;
        beat.last = last;
      end
      SEL_B: begin
        beat.addr = {pair, 1'b1};
        beat.data = buf_b;
        beat.last = last;
      end
`ifdef REG_DUMP_CHECKSUM_EN
      SEL_SUM: begin
        beat.data = sum_q;
        beat.last = last;
      end
`endif
      default: beat = '0;
    endcase
  end

endmodule

// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
// Read-side master for the MIPS_REG register file. On Start it sweeps all
// registers two at a time through the asynchronous read ports and streams
// each (address, data) pair out on a valid/ready interface.
// Widths come from mips_pkg (ADDR_W = 5, DATA_W = 32).
// Ports:
//   Clk, Reset           : clock, synchronous active-high reset
//   Start                : one-cycle dump request, honoured only in IDLE
//   Busy                 : high while a dump is in flight
//   Done                 : one-cycle pulse after the final beat handshake
//   R_Addr_A / R_Addr_B  : even / odd register of the current pair
//   R_Data_A / R_Data_B  : combinational read data for those addresses
//   Dump_Valid/Ready     : output beat handshake
//   Dump_Addr/Data/Last  : output beat contents
// Optional build macro: REG_DUMP_CHECKSUM_EN appends an XOR checksum beat
// (addr 0, Last=1) after register NUM_REGS-1.
// -----------------------------------------------------------------------------
module reg_dump_reader
  import mips_pkg::*;
#(
  parameter int NUM_REGS = 32  // even, <= 2**ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] R_Addr_A,
  output logic [ADDR_W-1:0] R_Addr_B,
  input  logic [DATA_W-1:0] R_Data_A,
  input  logic [DATA_W-1:0] R_Data_B,
  output logic              Dump_Valid,
  input  logic              Dump_Ready,
  output logic [ADDR_W-1:0] Dump_Addr,
  output logic [DATA_W-1:0] Dump_Data,
  output logic              Dump_Last
);

  localparam int                PAIR_W    = ADDR_W - 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_REGS / 2 - 1);

  dump_state_t       state_q, state_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic              capture;
  logic              beat_last;
  beat_sel_t         sel;
  beat_t             beat;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q;
    capture    = 1'b0;
    sel        = SEL_NONE;
    beat_last  = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    Dump_Valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          pair_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        Busy    = 1'b1;
        capture = 1'b1;
        state_d = ST_EMIT_A;
      end
      ST_EMIT_A: begin
        Busy       = 1'b1;
        Dump_Valid = 1'b1;
        sel        = SEL_A;
        if (Dump_Ready) state_d = ST_EMIT_B;
      end
      ST_EMIT_B: begin
        Busy       = 1'b1;
        Dump_Valid = 1'b1;
        sel        = SEL_B;
`ifndef REG_DUMP_CHECKSUM_EN
        beat_last  = (pair_q == LAST_PAIR);
`endif
        if (Dump_Ready) begin
          if (pair_q == LAST_PAIR) begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_d = ST_SUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            pair_d  = pair_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_SUM: begin
        Busy       = 1'b1;
        Dump_Valid = 1'b1;
        sel        = SEL_SUM;
        beat_last  = 1'b1;
        if (Dump_Ready) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        Done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign R_Addr_A = {pair_q, 1'b0};
  assign R_Addr_B = {pair_q, 1'b1};

  dump_beat_reg u_beat (
    .clk       (Clk),
    .reset     (Reset),
    .capture   (capture),
    .sel       (sel),
    .pair      (pair_q),
    .last      (beat_last),
    .data_a    (R_Data_A),
    .data_b    (R_Data_B),
`ifdef REG_DUMP_CHECKSUM_EN
    .clear_sum (state_q == ST_IDLE && Start),
`endif
    .beat      (beat)
  );

  assign Dump_Addr = beat.addr;
  assign Dump_Data = beat.data;
  assign Dump_Last = beat.last;

endmodule

// File: tb/tb_reg_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_reader
// Directed bench for reg_dump_reader with a behavioural 32 x 32 register file
// on the read ports. Inputs change on the falling edge; outputs are sampled
// on the falling edge. Cycle 0 is the cycle Start is high; the DUT is in
// READ in cycle 1, so Done is expected in cycle 49 (50 with the checksum).
// -----------------------------------------------------------------------------
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int DONE_CYC = CSUM ? 50 : 49;

  logic        Clk = 1'b0;
  logic        Reset, Start, Busy, Done;
  logic [4:0]  R_Addr_A, R_Addr_B, Dump_Addr;
  logic [31:0] R_Data_A, R_Data_B, Dump_Data;
  logic        Dump_Valid, Dump_Ready, Dump_Last;

  logic [31:0] rf [32];
  assign R_Data_A = rf[R_Addr_A];
  assign R_Data_B = rf[R_Addr_B];

  always #5 Clk = ~Clk;

  reg_dump_reader dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Busy       (Busy),
    .Done       (Done),
    .R_Addr_A   (R_Addr_A),
    .R_Addr_B   (R_Addr_B),
    .R_Data_A   (R_Data_A),
    .R_Data_B   (R_Data_B),
    .Dump_Valid (Dump_Valid),
    .Dump_Ready (Dump_Ready),
    .Dump_Addr  (Dump_Addr),
    .Dump_Data  (Dump_Data),
    .Dump_Last  (Dump_Last)
  );

  int checks   = 0;
  int failures = 0;

  // captured run
  logic [4:0]  got_addr [64];
  logic [31:0] got_data [64];
  logic        got_last [64];
  int          n_beats, done_count, done_cyc, hold_errs, stall_hits;
  logic        busy1;

  // expectation
  logic [31:0] exp_mem  [32];
  logic [4:0]  exp_addr [64];
  logic [31:0] exp_data [64];
  logic        exp_last [64];
  int          n_exp;

  task automatic preload();
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'h1111_1111;
    rf[2] = 32'h2222_2222;
    for (int i = 0; i < 32; i++) exp_mem[i] = rf[i];
  endtask

  task automatic fill_expected();
    logic [31:0] sum;
    sum = 32'h0;
    for (int i = 0; i < 32; i++) begin
      exp_addr[i] = 5'(i);
      exp_data[i] = exp_mem[i];
      exp_last[i] = (i == 31) && !CSUM;
      sum ^= exp_mem[i];
    end
    n_exp = 32;
    if (CSUM) begin
      exp_addr[32] = 5'd0;
      exp_data[32] = sum;
      exp_last[32] = 1'b1;
      n_exp = 33;
    end
  endtask

  // Runs one dump for 90 cycles, recording every handshaken beat.
  // stall_addr: drop Ready for 5 cycles when that beat first appears.
  // start_addr: re-pulse Start when that beat first appears.
  // hook_addr : on first sight of that beat, write r2 and r20 in the file.
  task automatic run_dump(input int stall_addr, input int start_addr,
                          input int hook_addr, input bit start_on_done);
    int          stall_left = 0;
    bit          stalled = 0, restarted = 0, hooked = 0;
    logic        prev_valid = 1'b0, prev_ready = 1'b1, prev_last = 1'b0;
    logic [4:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    n_beats = 0; done_count = 0; done_cyc = -1; hold_errs = 0;
    stall_hits = 0; busy1 = 1'b0;
    @(negedge Clk);
    Dump_Ready = 1'b1;
    Start      = 1'b1;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (cyc == 1) busy1 = Busy;
      if (Done) begin
        done_count++;
        if (done_cyc < 0) done_cyc = cyc;
        if (start_on_done) Start = 1'b1;
      end
      if (prev_valid && !prev_ready &&
          (!Dump_Valid || Dump_Addr !== prev_addr || Dump_Data !== prev_data ||
           Dump_Last !== prev_last))
        hold_errs++;
      if (Dump_Valid && int'(Dump_Addr) == hook_addr && !hooked) begin
        hooked = 1;
        rf[2]  = 32'h5555_5555;
        rf[20] = 32'hABCD_0123;
      end
      if (Dump_Valid && int'(Dump_Addr) == stall_addr && !stalled) begin
        stalled    = 1;
        stall_left = 5;
      end
      Dump_Ready = (stall_left == 0);
      if (stall_left > 0) begin
        stall_left--;
        if (Dump_Valid && int'(Dump_Addr) == stall_addr && Dump_Data === exp_mem[stall_addr])
          stall_hits++;
      end
      if (Dump_Valid && int'(Dump_Addr) == start_addr && !restarted) begin
        restarted = 1;
        Start     = 1'b1;
      end
      if (Dump_Valid && Dump_Ready) begin
        if (n_beats < 64) begin
          got_addr[n_beats] = Dump_Addr;
          got_data[n_beats] = Dump_Data;
          got_last[n_beats] = Dump_Last;
        end
        n_beats++;
      end
      prev_valid = Dump_Valid;
      prev_ready = Dump_Ready;
      prev_addr  = Dump_Addr;
      prev_data  = Dump_Data;
      prev_last  = Dump_Last;
    end
    Start      = 1'b0;
    Dump_Ready = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b0;
    Dump_Ready = 1'b1;
    preload();
    repeat (2) @(negedge Clk);
    checks++;
    if ({Busy, Done, Dump_Valid, Dump_Last} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got busy/done/valid/last=%b expected 0000",
               {Busy, Done, Dump_Valid, Dump_Last});
    end
    checks++;
    if (Dump_Addr !== 5'd0 || Dump_Data !== 32'h0) begin
      failures++;
      $display("FAIL reset_beat got addr=%0d data=%h expected addr=0 data=0", Dump_Addr, Dump_Data);
    end
    checks++;
    if (R_Addr_A !== 5'd0 || R_Addr_B !== 5'd1) begin
      failures++;
      $display("FAIL reset_raddr got A=%0d B=%0d expected A=0 B=1", R_Addr_A, R_Addr_B);
    end
    Reset = 1'b0;
  endtask

  task automatic test_full_dump();
    preload();
    fill_expected();
    run_dump(-1, -1, -1, 1'b1);
    checks++;
    if (n_beats !== n_exp) begin
      failures++;
      $display("FAIL full_count got %0d beats expected %0d", n_beats, n_exp);
    end
    for (int i = 0; i < n_exp && i < n_beats; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL full_beat[%0d] got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                 i, got_addr[i], got_data[i], got_last[i], exp_addr[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (done_cyc !== DONE_CYC || done_count !== 1) begin
      failures++;
      $display("FAIL full_done got cycle=%0d count=%0d expected cycle=%0d count=1",
               done_cyc, done_count, DONE_CYC);
    end
    checks++;
    if (busy1 !== 1'b1) begin
      failures++;
      $display("FAIL full_busy got %b in cycle 1 expected 1", busy1);
    end
  endtask

  task automatic test_backpressure();
    preload();
    fill_expected();
    run_dump(1, -1, -1, 1'b0);
    checks++;
    if (hold_errs !== 0 || stall_hits !== 5) begin
      failures++;
      $display("FAIL bp_hold got hold_errs=%0d stable_cycles=%0d expected 0 and 5", hold_errs, stall_hits);
    end
    checks++;
    if (n_beats !== n_exp) begin
      failures++;
      $display("FAIL bp_count got %0d beats expected %0d", n_beats, n_exp);
    end
    for (int i = 0; i < n_exp && i < n_beats; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL bp_beat[%0d] got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                 i, got_addr[i], got_data[i], got_last[i], exp_addr[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (done_cyc !== DONE_CYC + 5 || done_count !== 1) begin
      failures++;
      $display("FAIL bp_done got cycle=%0d count=%0d expected cycle=%0d count=1",
               done_cyc, done_count, DONE_CYC + 5);
    end
  endtask

  task automatic test_start_while_busy();
    preload();
    fill_expected();
    run_dump(-1, 6, -1, 1'b0);
    checks++;
    if (n_beats !== n_exp) begin
      failures++;
      $display("FAIL busy_count got %0d beats expected %0d", n_beats, n_exp);
    end
    for (int i = 0; i < n_exp && i < n_beats; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL busy_beat[%0d] got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                 i, got_addr[i], got_data[i], got_last[i], exp_addr[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (done_count !== 1 || done_cyc !== DONE_CYC) begin
      failures++;
      $display("FAIL busy_done got count=%0d cycle=%0d expected count=1 cycle=%0d",
               done_count, done_cyc, DONE_CYC);
    end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    preload();
    fill_expected();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    while (!(Dump_Valid && Dump_Addr == 5'd10) && waited < 100) begin
      @(negedge Clk);
      waited++;
    end
    checks++;
    if (waited >= 100) begin
      failures++;
      $display("FAIL rstmid_wait got no addr-10 beat within %0d cycles expected one", waited);
    end
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if ({Dump_Valid, Busy, Done} !== 3'b000 || R_Addr_A !== 5'd0) begin
      failures++;
      $display("FAIL rstmid_state got valid/busy/done=%b raddr_a=%0d expected 000 and 0",
               {Dump_Valid, Busy, Done}, R_Addr_A);
    end
    Reset = 1'b0;
    run_dump(-1, -1, -1, 1'b0);
    checks++;
    if (n_beats !== n_exp || done_count !== 1) begin
      failures++;
      $display("FAIL rstmid_redump got beats=%0d dones=%0d expected %0d and 1", n_beats, done_count, n_exp);
    end
    for (int i = 0; i < n_exp && i < n_beats; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL rstmid_beat[%0d] got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                 i, got_addr[i], got_data[i], got_last[i], exp_addr[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_live_write();
    preload();
    // r20 is written before pair 10 is read, r2 after pair 1 was captured.
    exp_mem[20] = 32'hABCD_0123;
    fill_expected();
    run_dump(-1, -1, 2, 1'b0);
    checks++;
    if (n_beats !== n_exp) begin
      failures++;
      $display("FAIL live_count got %0d beats expected %0d", n_beats, n_exp);
    end
    for (int i = 0; i < n_exp && i < n_beats; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL live_beat[%0d] got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                 i, got_addr[i], got_data[i], got_last[i], exp_addr[i], exp_data[i], exp_last[i]);
      end
    end
    preload();
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_live_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
